// File: rtl/kbd_pkg.sv
// Shared scancode constants and state/direction types for the PS/2 set-2 key decoder.
package kbd_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} kbd_state_t;

  typedef enum logic {RIGHT, LEFT} dir_t;

endpackage

// File: rtl/kbd_key_decoder.sv
// PS/2 set-2 scancode bytes -> registered held-key levels for player control.
// Define KBD_WASD_EN to make A/D aliases of the LEFT/RIGHT arrow keys.
module kbd_key_decoder
  import kbd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TIMEOUT_W      = 16
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       right,
  output logic       left,
  output logic       fire,
  output logic       fire_pulse,
  output logic       start,
  output logic       prefix_err
);

  localparam logic [TIMEOUT_W-1:0] CNT_MAX = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  kbd_state_t           state_reg, state_next;
  logic [TIMEOUT_W-1:0] cnt_reg, cnt_next;
  dir_t                 last_dir_reg, last_dir_next;
  logic hold_l_reg, hold_l_next, hold_r_reg, hold_r_next;
  logic hold_sp_reg, hold_sp_next, hold_en_reg, hold_en_next;
  logic right_reg, right_next, left_reg, left_next;
  logic fire_pulse_reg, fire_pulse_next, prefix_err_reg, prefix_err_next;
  logic key_ev, key_make, key_ext;
  logic l_held_next, r_held_next;
`ifdef KBD_WASD_EN
  logic hold_a_reg, hold_a_next, hold_d_reg, hold_d_next;
`endif

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    last_dir_next   = last_dir_reg;
    hold_l_next     = hold_l_reg;
    hold_r_next     = hold_r_reg;
    hold_sp_next    = hold_sp_reg;
    hold_en_next    = hold_en_reg;
    fire_pulse_next = 1'b0;
    prefix_err_next = 1'b0;
    key_ev          = 1'b0;
    key_make        = 1'b0;
    key_ext         = 1'b0;
`ifdef KBD_WASD_EN
    hold_a_next     = hold_a_reg;
    hold_d_next     = hold_d_reg;
`endif

    if (din_valid) begin
      cnt_next = '0;
      case (state_reg)
        IDLE: begin
          if (din == SC_EXT)      state_next = EXT;
          else if (din == SC_BRK) state_next = BRK;
          else begin
            key_ev   = 1'b1;
            key_make = 1'b1;
          end
        end
        EXT: begin
          state_next = IDLE;
          if (din == SC_BRK)      state_next = EXT_BRK;
          else if (din == SC_EXT) prefix_err_next = 1'b1;
          else begin
            key_ev   = 1'b1;
            key_make = 1'b1;
            key_ext  = 1'b1;
          end
        end
        BRK: begin
          state_next = IDLE;
          if (din == SC_BRK) prefix_err_next = 1'b1;
          else               key_ev = 1'b1;
        end
        EXT_BRK: begin
          state_next = IDLE;
          if (din == SC_BRK || din == SC_EXT) prefix_err_next = 1'b1;
          else begin
            key_ev  = 1'b1;
            key_ext = 1'b1;
          end
        end
      endcase
    end else if (state_reg == IDLE) begin
      cnt_next = '0;
    end else if (cnt_reg == CNT_MAX) begin
      state_next      = IDLE;
      cnt_next        = '0;
      prefix_err_next = 1'b1;
    end else begin
      cnt_next = cnt_reg + TIMEOUT_W'(1);
    end

    // A make of an already-held key is typematic repeat and changes nothing.
    if (key_ev) begin
      if (key_ext && din == SC_LEFT) begin
        if (!key_make) hold_l_next = 1'b0;
        else if (!hold_l_reg) begin
          hold_l_next   = 1'b1;
          last_dir_next = LEFT;
        end
      end else if (key_ext && din == SC_RIGHT) begin
        if (!key_make) hold_r_next = 1'b0;
        else if (!hold_r_reg) begin
          hold_r_next   = 1'b1;
          last_dir_next = RIGHT;
        end
      end else if (!key_ext && din == SC_SPACE) begin
        if (!key_make) hold_sp_next = 1'b0;
        else if (!hold_sp_reg) begin
          hold_sp_next    = 1'b1;
          fire_pulse_next = 1'b1;
        end
      end else if (!key_ext && din == SC_ENTER) begin
        hold_en_next = key_make;
`ifdef KBD_WASD_EN
      end else if (!key_ext && din == SC_A) begin
        if (!key_make) hold_a_next = 1'b0;
        else if (!hold_a_reg) begin
          hold_a_next   = 1'b1;
          last_dir_next = LEFT;
        end
      end else if (!key_ext && din == SC_D) begin
        if (!key_make) hold_d_next = 1'b0;
        else if (!hold_d_reg) begin
          hold_d_next   = 1'b1;
          last_dir_next = RIGHT;
        end
`endif
      end
    end

`ifdef KBD_WASD_EN
    l_held_next = hold_l_next | hold_a_next;
    r_held_next = hold_r_next | hold_d_next;
`else
    l_held_next = hold_l_next;
    r_held_next = hold_r_next;
`endif
    // Most recent fresh direction wins when both are held.
    right_next = r_held_next & (~l_held_next | (last_dir_next == RIGHT));
    left_next  = l_held_next & (~r_held_next | (last_dir_next == LEFT));
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      last_dir_reg   <= RIGHT;
      hold_l_reg     <= 1'b0;
      hold_r_reg     <= 1'b0;
      hold_sp_reg    <= 1'b0;
      hold_en_reg    <= 1'b0;
      right_reg      <= 1'b0;
      left_reg       <= 1'b0;
      fire_pulse_reg <= 1'b0;
      prefix_err_reg <= 1'b0;
`ifdef KBD_WASD_EN
      hold_a_reg     <= 1'b0;
      hold_d_reg     <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      last_dir_reg   <= last_dir_next;
      hold_l_reg     <= hold_l_next;
      hold_r_reg     <= hold_r_next;
      hold_sp_reg    <= hold_sp_next;
      hold_en_reg    <= hold_en_next;
      right_reg      <= right_next;
      left_reg       <= left_next;
      fire_pulse_reg <= fire_pulse_next;
      prefix_err_reg <= prefix_err_next;
`ifdef KBD_WASD_EN
      hold_a_reg     <= hold_a_next;
      hold_d_reg     <= hold_d_next;
`endif
    end
  end

  assign right      = right_reg;
  assign left       = left_reg;
  assign fire       = hold_sp_reg;
  assign fire_pulse = fire_pulse_reg;
  assign start      = hold_en_reg;
  assign prefix_err = prefix_err_reg;

endmodule
